nway_cache_control: RTL and testbench

NWAY_CACHE_CONTROL -- requirements
Module: nway_cache_control

---
 rtl/cache_types.sv | 63 ++++++
 rtl/nway_cache_control_if.sv | 55 +++++
 rtl/plru_tree.sv | 29 ++
 rtl/nway_cache_control.sv | 157 +++++++++++++++
 tb/tb_nway_cache_control.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_types.sv
// Shared types and tree-PLRU helpers for the n-way cache controller.
//   state_t / IDLE..ALLOCATE : controller FSM encoding
//   plru_victim()            : walk the PLRU tree to the way it points at
//   plru_update()            : point every node on a way's path away from it
// Tree layout: node n has children 2n+1 (lower-index ways) and 2n+2 (upper).
// A node bit of 0 means the victim lies in the lower-index subtree.
// Functions operate on the largest supported tree (8 ways) and take the
// actual associativity as an argument; callers zero-extend and truncate.
package cache_types;

    localparam int unsigned MAX_WAY_W  = 3;
    localparam int unsigned MAX_PLRU_W = 7;

    typedef logic [1:0] state_t;

    localparam state_t IDLE      = 2'd0;
    localparam state_t TAG_CHECK = 2'd1;
    localparam state_t WRITEBACK = 2'd2;
    localparam state_t ALLOCATE  = 2'd3;

    function automatic logic [MAX_WAY_W-1:0] plru_victim(
        input logic [MAX_PLRU_W-1:0] bits,
        input int unsigned           ways
    );
        int unsigned node;
        int unsigned levels;
        node   = 0;
        levels = $clog2(ways);
        for (int unsigned l = 0; l < MAX_WAY_W; l++) begin
            if (l < levels) begin
                node = bits[node[2:0]] ? (2 * node + 2) : (2 * node + 1);
            end
        end
        // Leaves are numbered after the ways-1 internal nodes.
        return MAX_WAY_W'(node - (ways - 1));
    endfunction

    function automatic logic [MAX_PLRU_W-1:0] plru_update(
        input logic [MAX_PLRU_W-1:0] bits,
        input logic [MAX_WAY_W-1:0]  way,
        input int unsigned           ways
    );
        logic [MAX_PLRU_W-1:0] nxt;
        int unsigned           node;
        int unsigned           levels;
        int unsigned           wv;
        logic                  dir;
        nxt    = bits;
        node   = 0;
        levels = $clog2(ways);
        wv     = 32'(way);
        for (int unsigned l = 0; l < MAX_WAY_W; l++) begin
            if (l < levels) begin
                // dir = 1 when the accessed way sits in the upper subtree.
                dir = ((wv >> (levels - 1 - l)) & 32'd1) != 32'd0;
                nxt[node[2:0]] = ~dir;
                node = dir ? (2 * node + 2) : (2 * node + 1);
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/nway_cache_control_if.sv
// Bus bundle between the cache controller and its surroundings.
//   CPU side   : mem_read, mem_write -> mem_resp
//   Set lookup : hit_vec, valid_vec, dirty_vec, plru_bits
//   Memory     : pmem_read, pmem_write, pmem_addr_sel <- pmem_resp
//   Array ctrl : way_sel, ld_data, data_src, ld_tag, set_valid, set_dirty,
//                clr_dirty, ld_plru, plru_next
//   Status     : hit_cnt, miss_cnt, wb_cnt, err_multihit
// slave  : the controller's view; master : the environment's view.
interface nway_cache_control_if #(
    parameter int unsigned WAYS  = 4,
    parameter int unsigned CNT_W = 32
);
    localparam int unsigned WAY_W  = $clog2(WAYS);
    localparam int unsigned PLRU_W = WAYS - 1;

    logic              mem_read;
    logic              mem_write;
    logic              mem_resp;
    logic [WAYS-1:0]   hit_vec;
    logic [WAYS-1:0]   valid_vec;
    logic [WAYS-1:0]   dirty_vec;
    logic [PLRU_W-1:0] plru_bits;
    logic              pmem_read;
    logic              pmem_write;
    logic              pmem_resp;
    logic              pmem_addr_sel;
    logic [WAY_W-1:0]  way_sel;
    logic              ld_data;
    logic              data_src;
    logic              ld_tag;
    logic              set_valid;
    logic              set_dirty;
    logic              clr_dirty;
    logic              ld_plru;
    logic [PLRU_W-1:0] plru_next;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;
    logic [CNT_W-1:0]  wb_cnt;
    logic              err_multihit;

    modport slave (
        input  mem_read, mem_write, hit_vec, valid_vec, dirty_vec, plru_bits, pmem_resp,
        output mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel, ld_data, data_src,
               ld_tag, set_valid, set_dirty, clr_dirty, ld_plru, plru_next,
               hit_cnt, miss_cnt, wb_cnt, err_multihit
    );

    modport master (
        output mem_read, mem_write, hit_vec, valid_vec, dirty_vec, plru_bits, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel, ld_data, data_src,
               ld_tag, set_valid, set_dirty, clr_dirty, ld_plru, plru_next,
               hit_cnt, miss_cnt, wb_cnt, err_multihit
    );

endinterface

// File: rtl/plru_tree.sv
// Combinational tree-PLRU block.
//   plru_bits  : current tree state for the set
//   access_way : way being touched this cycle
//   victim     : way the current tree points at
//   plru_next  : tree state after touching access_way
module plru_tree
    import cache_types::*;
#(
    parameter int unsigned WAYS = 4,
    localparam int unsigned WAY_W  = $clog2(WAYS),
    localparam int unsigned PLRU_W = WAYS - 1
) (
    input  logic [PLRU_W-1:0] plru_bits,
    input  logic [WAY_W-1:0]  access_way,
    output logic [WAY_W-1:0]  victim,
    output logic [PLRU_W-1:0] plru_next
);

    logic [MAX_PLRU_W-1:0] bits_ext;
    logic [MAX_WAY_W-1:0]  way_ext;

    always_comb begin
        bits_ext  = MAX_PLRU_W'(plru_bits);
        way_ext   = MAX_WAY_W'(access_way);
        victim    = WAY_W'(plru_victim(bits_ext, WAYS));
        plru_next = PLRU_W'(plru_update(bits_ext, way_ext, WAYS));
    end

endmodule

// File: rtl/nway_cache_control.sv
// N-way set-associative cache controller FSM (write-back, write-allocate).
//   clk, rst : clock and asynchronous active-high reset
//   bus      : nway_cache_control_if.slave, CPU/array/memory signals
// A request is examined in TAG_CHECK; a hit completes there. A miss latches a
// victim (first invalid way, else PLRU), writes it back if dirty, refills it,
// and returns to TAG_CHECK where the refilled line hits and completes.
module nway_cache_control
    import cache_types::*;
#(
    parameter int unsigned WAYS  = 4,
    parameter int unsigned CNT_W = 32
) (
    input logic                 clk,
    input logic                 rst,
    nway_cache_control_if.slave bus
);

    localparam int unsigned WAY_W  = $clog2(WAYS);
    localparam int unsigned PLRU_W = WAYS - 1;

    state_t           state_q, state_d;
    logic [WAY_W-1:0] victim_q, victim_d;
    logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
    logic             err_q;

    logic             hit_inc, miss_inc, wb_inc, multihit_set;
    logic             req, is_write, any_hit, multi_hit, has_invalid;
    logic [WAY_W-1:0] hit_way, inv_way, plru_victim_way, miss_victim;
    logic [PLRU_W-1:0] plru_upd;

    plru_tree #(
        .WAYS(WAYS)
    ) u_plru_tree (
        .plru_bits (bus.plru_bits),
        .access_way(hit_way),
        .victim    (plru_victim_way),
        .plru_next (plru_upd)
    );

    // Lowest set index wins, so scan from the top down.
    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int i = int'(WAYS) - 1; i >= 0; i--) begin
            if (bus.hit_vec[i]) hit_way = WAY_W'(i);
            if (!bus.valid_vec[i]) inv_way = WAY_W'(i);
        end
    end

    always_comb begin
        req         = bus.mem_read | bus.mem_write;
        is_write    = bus.mem_write & ~bus.mem_read;
        any_hit     = |bus.hit_vec;
        multi_hit   = |(bus.hit_vec & (bus.hit_vec - WAYS'(1)));
        has_invalid = |(~bus.valid_vec);
        miss_victim = has_invalid ? inv_way : plru_victim_way;
    end

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        wb_inc       = 1'b0;
        multihit_set = 1'b0;

        bus.mem_resp      = 1'b0;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        bus.pmem_addr_sel = 1'b0;
        bus.way_sel       = '0;
        bus.ld_data       = 1'b0;
        bus.data_src      = 1'b0;
        bus.ld_tag        = 1'b0;
        bus.set_valid     = 1'b0;
        bus.set_dirty     = 1'b0;
        bus.clr_dirty     = 1'b0;
        bus.ld_plru       = 1'b0;
        bus.plru_next     = '0;

        case (state_q)
            IDLE: begin
                if (req) state_d = TAG_CHECK;
            end
            TAG_CHECK: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (any_hit) begin
                    bus.mem_resp  = 1'b1;
                    bus.way_sel   = hit_way;
                    bus.ld_plru   = 1'b1;
                    bus.plru_next = plru_upd;
                    bus.ld_data   = is_write;
                    bus.set_dirty = is_write;
                    hit_inc       = 1'b1;
                    multihit_set  = multi_hit;
                    state_d       = IDLE;
                end else begin
                    victim_d = miss_victim;
                    miss_inc = 1'b1;
                    if (bus.valid_vec[miss_victim] && bus.dirty_vec[miss_victim]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write    = 1'b1;
                bus.pmem_addr_sel = 1'b1;
                bus.way_sel       = victim_q;
                if (bus.pmem_resp) begin
                    wb_inc        = 1'b1;
                    bus.clr_dirty = 1'b1;
                    state_d       = ALLOCATE;
                end
            end
            ALLOCATE: begin
                bus.pmem_read = 1'b1;
                bus.way_sel   = victim_q;
                if (bus.pmem_resp) begin
                    bus.ld_data   = 1'b1;
                    bus.data_src  = 1'b1;
                    bus.ld_tag    = 1'b1;
                    bus.set_valid = 1'b1;
                    bus.clr_dirty = 1'b1;
                    state_d       = TAG_CHECK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            victim_q   <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            if (hit_inc && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            if (miss_inc && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            if (wb_inc && (wb_cnt_q != '1)) wb_cnt_q <= wb_cnt_q + CNT_W'(1);
            if (multihit_set) err_q <= 1'b1;
        end
    end

    assign bus.hit_cnt      = hit_cnt_q;
    assign bus.miss_cnt     = miss_cnt_q;
    assign bus.wb_cnt       = wb_cnt_q;
    assign bus.err_multihit = err_q;

endmodule

// File: tb/tb_nway_cache_control.sv
// Scoreboard bench for nway_cache_control (WAYS=4, narrow counters so
// saturation is reachable). Stimulus pushes expected strobe events; the
// monitor pops one whenever the DUT shows mem_resp, a refill or a writeback.
module tb_nway_cache_control;

    localparam int unsigned WAYS  = 4;
    localparam int unsigned CNT_W = 3;

    localparam logic [1:0] K_RESP = 2'd0;
    localparam logic [1:0] K_FILL = 2'd1;
    localparam logic [1:0] K_WB   = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] way;
        logic       we;
        logic [2:0] pnext;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nway_cache_control_if #(.WAYS(WAYS), .CNT_W(CNT_W)) bus ();

    nway_cache_control #(.WAYS(WAYS), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    exp_t        mon_e;
    logic [15:0] mon_act;

    // {way_sel, mem_resp, ld_plru, plru_next, ld_data, data_src, ld_tag,
    //  set_valid, set_dirty, clr_dirty, pmem_read, pmem_write, pmem_addr_sel}
    function automatic logic [15:0] exp_vec(input exp_t e);
        case (e.kind)
            K_RESP:  return {e.way, 1'b1, 1'b1, e.pnext, e.we, 1'b0, 1'b0, 1'b0, e.we,
                             1'b0, 1'b0, 1'b0, 1'b0};
            K_FILL:  return {e.way, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                             1'b1, 1'b1, 1'b0, 1'b0};
            default: return {e.way, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b1, 1'b0, 1'b1, 1'b1};
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pmem_read || bus.pmem_write) begin
                n_cmp++;
                if (bus.pmem_read && bus.pmem_write) begin
                    n_fail++;
                    $display("FAIL pmem_exclusive: got read=1 write=1 required at most one");
                end
            end
            if (bus.mem_resp || bus.ld_tag || (bus.pmem_write && bus.pmem_resp)) begin
                mon_act = {bus.way_sel, bus.mem_resp, bus.ld_plru, bus.plru_next, bus.ld_data,
                           bus.data_src, bus.ld_tag, bus.set_valid, bus.set_dirty,
                           bus.clr_dirty, bus.pmem_read, bus.pmem_write, bus.pmem_addr_sel};
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got strobes %h with nothing expected",
                             mon_act);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_act !== exp_vec(mon_e)) begin
                        n_fail++;
                        $display("FAIL event_kind%0d_way%0d: got strobes %h required %h",
                                 mon_e.kind, mon_e.way, mon_act, exp_vec(mon_e));
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] kind, input logic [1:0] way, input logic we,
                            input logic [2:0] pnext);
        exp_t e;
        e.kind  = kind;
        e.way   = way;
        e.we    = we;
        e.pnext = pnext;
        sb.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.hit_vec   = '0;
        bus.valid_vec = '0;
        bus.dirty_vec = '0;
        bus.plru_bits = '0;
        bus.pmem_resp = 1'b0;
    endtask

    // Waits for mem_resp, returns the number of falling edges it took, then drops the request.
    task automatic wait_resp(input string name, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 30) begin
            @(negedge clk);
            lat++;
            if (bus.mem_resp) seen = 1'b1;
        end
        check({name, "_resp_seen"}, 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.hit_vec   = '0;
    endtask

    task automatic do_hit(input string name, input logic rd, input logic wr,
                          input logic [3:0] hit, input logic [2:0] plru,
                          input logic [1:0] exp_way, input logic [2:0] exp_pnext);
        int lat;
        @(posedge clk);
        #1;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.hit_vec   = hit;
        bus.valid_vec = '1;
        bus.dirty_vec = '0;
        bus.plru_bits = plru;
        push_exp(K_RESP, exp_way, wr & ~rd, exp_pnext);
        wait_resp(name, lat);
        check({name, "_latency"}, 32'(lat), 32'd2);
    endtask

    // Serves one memory operation after a fixed delay; live set inputs are
    // scrambled meanwhile so way_sel must come from the latched victim.
    task automatic pmem_service(input string name, input bit wb, input int delay);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.pmem_read || bus.pmem_write) seen = 1'b1;
        end
        check({name, "_pmem_op"}, {30'd0, bus.pmem_write, bus.pmem_read},
              wb ? 32'd2 : 32'd1);
        if (seen) begin
            @(posedge clk);
            #1;
            bus.valid_vec = '1;
            bus.dirty_vec = '1;
            bus.plru_bits = 3'b111;
            repeat (delay - 1) @(posedge clk);
            #1;
            bus.pmem_resp = 1'b1;
            @(posedge clk);
            #1;
            bus.pmem_resp = 1'b0;
        end
    endtask

    task automatic do_miss(input string name, input logic rd, input logic wr,
                           input logic [3:0] valid, input logic [3:0] dirty,
                           input logic [2:0] plru, input logic [1:0] exp_victim,
                           input bit exp_wb, input logic [2:0] exp_pnext);
        int         lat;
        logic [3:0] onehot;
        onehot = 4'b0001 << exp_victim;
        @(posedge clk);
        #1;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.hit_vec   = '0;
        bus.valid_vec = valid;
        bus.dirty_vec = dirty;
        bus.plru_bits = plru;
        if (exp_wb) push_exp(K_WB, exp_victim, 1'b0, 3'b000);
        push_exp(K_FILL, exp_victim, 1'b0, 3'b000);
        push_exp(K_RESP, exp_victim, wr & ~rd, exp_pnext);
        if (exp_wb) pmem_service({name, "_wb"}, 1'b1, 2);
        pmem_service({name, "_fill"}, 1'b0, 3);
        // Now in the re-check: the refilled line hits.
        bus.hit_vec   = onehot;
        bus.valid_vec = '1;
        bus.dirty_vec = '0;
        bus.plru_bits = plru;
        wait_resp(name, lat);
    endtask

    task automatic check_cnts(input string name, input int h, input int m, input int w);
        check({name, "_hit_cnt"}, 32'(bus.hit_cnt), 32'(h));
        check({name, "_miss_cnt"}, 32'(bus.miss_cnt), 32'(m));
        check({name, "_wb_cnt"}, 32'(bus.wb_cnt), 32'(w));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_cnts("reset", 0, 0, 0);
        check("reset_err", 32'(bus.err_multihit), 32'd0);
        check("reset_outs", {29'd0, bus.mem_resp, bus.pmem_read, bus.pmem_write}, 32'd0);
        rst = 1'b0;

        do_hit("rd_hit_w2", 1'b1, 1'b0, 4'b0100, 3'b000, 2'd2, 3'b100);
        check_cnts("rd_hit_w2", 1, 0, 0);
        do_hit("wr_hit_w1", 1'b0, 1'b1, 4'b0010, 3'b000, 2'd1, 3'b001);
        check_cnts("wr_hit_w1", 2, 0, 0);
        do_hit("rdwr_hit_w3", 1'b1, 1'b1, 4'b1000, 3'b111, 2'd3, 3'b010);
        check_cnts("rdwr_hit_w3", 3, 0, 0);

        do_miss("rd_miss_inv", 1'b1, 1'b0, 4'b1011, 4'b1111, 3'b000, 2'd2, 1'b0, 3'b100);
        check_cnts("rd_miss_inv", 4, 1, 0);
        do_miss("rd_miss_plru", 1'b1, 1'b0, 4'b1111, 4'b0000, 3'b101, 2'd3, 1'b0, 3'b000);
        check_cnts("rd_miss_plru", 5, 2, 0);
        do_miss("wr_miss_wb", 1'b0, 1'b1, 4'b1111, 4'b0001, 3'b000, 2'd0, 1'b1, 3'b011);
        check_cnts("wr_miss_wb", 6, 3, 1);

        // Request withdrawn in TAG_CHECK, with a stray pmem_resp there too.
        @(posedge clk);
        #1;
        bus.mem_read = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.pmem_resp = 1'b1;
        @(negedge clk);
        check("noreq_strobes", {26'd0, bus.mem_resp, bus.pmem_read, bus.pmem_write,
              bus.ld_data, bus.set_valid, bus.clr_dirty}, 32'd0);
        @(posedge clk);
        #1;
        bus.pmem_resp = 1'b0;
        @(negedge clk);
        check("noreq_pmem_read", 32'(bus.pmem_read), 32'd0);
        check_cnts("noreq", 6, 3, 1);

        // Stray pmem_resp in IDLE.
        @(posedge clk);
        #1;
        bus.pmem_resp = 1'b1;
        @(negedge clk);
        check("idle_resp_strobes", {29'd0, bus.mem_resp, bus.pmem_read, bus.pmem_write},
              32'd0);
        @(posedge clk);
        #1;
        bus.pmem_resp = 1'b0;
        do_hit("rd_hit_w0", 1'b1, 1'b0, 4'b0001, 3'b000, 2'd0, 3'b011);
        check_cnts("rd_hit_w0", 7, 3, 1);

        do_hit("multihit", 1'b1, 1'b0, 4'b0110, 3'b000, 2'd1, 3'b001);
        check("multihit_err", 32'(bus.err_multihit), 32'd1);
        check("multihit_sat", 32'(bus.hit_cnt), 32'd7);
        do_hit("after_multi", 1'b1, 1'b0, 4'b1000, 3'b000, 2'd3, 3'b000);
        check("after_multi_err", 32'(bus.err_multihit), 32'd1);
        check("after_multi_sat", 32'(bus.hit_cnt), 32'd7);

        // Reset in the middle of a writeback.
        @(posedge clk);
        #1;
        bus.mem_write = 1'b1;
        bus.valid_vec = '1;
        bus.dirty_vec = 4'b0001;
        bus.plru_bits = 3'b000;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.pmem_write) seen = 1'b1;
        end
        check("rstwb_in_wb", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rstwb_pmem_write", 32'(bus.pmem_write), 32'd0);
        check_cnts("rstwb", 0, 0, 0);
        check("rstwb_err", 32'(bus.err_multihit), 32'd0);
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstwb_idle", {30'd0, bus.pmem_read, bus.pmem_write}, 32'd0);

        do_hit("post_rst_hit", 1'b1, 1'b0, 4'b0100, 3'b000, 2'd2, 3'b100);
        check_cnts("post_rst_hit", 1, 0, 0);
        check("post_rst_err", 32'(bus.err_multihit), 32'd0);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
